uart_tx_ctrl: RTL and testbench
===============================

Name: uart_tx_ctrl

Overview:
Frame controller and serializer for the UART transmit path, directly upstream of the TX output multiplexer. It accepts a parallel word with a valid strobe and latches the word and the parity configuration. It then sequences start, data (LSB first), optional parity and stop phases. It drives the serial data bit, parity bit, latched parity enable and 2-bit mux select consumed by the output mux. One UART bit is sent per CLK cycle; CLK is the bit clock.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (range 5..9).

Ports:
- CLK       input   1           bit clock, rising-edge.
- RST       input   1           reset, asynchronous, active-low.
- P_DATA    input   DATA_WIDTH  parallel word to transmit.
- Data_Valid input  1           request strobe; P_DATA, PAR_EN and PAR_TYP are sampled when it is accepted.
- PAR_EN    input   1           1 = parity phase included.
- PAR_TYP   input   1           0 = even parity, 1 = odd parity.
- ser_data  output  1           current data bit to the mux.
- par_bit   output  1           parity bit of the latched word.
- par_en_q  output  1           PAR_EN latched at frame accept; drives the mux PAR_EN input.
- mux_sel   output  2           00 start, 01 data, 10 parity, 11 stop/idle.
- busy      output  1           high while a frame is in progress.

Behaviour:
- Reset (RST=0, asynchronous):
  - state = IDLE; mux_sel = 11; busy = 0; ser_data = 0; par_bit = 0; par_en_q = 0.
  - Shift register and bit counter are cleared.
  - Reset mid-frame aborts the frame immediately; the line returns to idle-high via mux_sel = 11.
- States and mux_sel encoding (Moore outputs, from registered state): IDLE (11), START (01→ see below), DATA (01), PARITY (10), STOP (11).
  - START drives mux_sel = 00.
- Accept condition: Data_Valid = 1 while state is IDLE or STOP.
  - On the accepting edge: latch P_DATA into the shift register and PAR_EN into par_en_q.
  - On the same edge: par_bit = ^P_DATA XOR PAR_TYP, registered.
  - Next state = START; busy = 1.
  - Data_Valid is ignored in START, DATA and PARITY. The latched word is unaffected by P_DATA changes.
- START: one cycle, then DATA. The bit counter is cleared on entry to DATA.
- DATA: DATA_WIDTH cycles.
  - ser_data = shift_reg[0] during each cycle; the shift register shifts right at the end of each cycle.
  - The bit counter increments each cycle.
  - On the last bit (counter = DATA_WIDTH-1), next state = PARITY if par_en_q, else STOP.
- PARITY: one cycle, then STOP.
- STOP: one cycle.
  - If an accept occurs, next state = START and busy stays 1 (back-to-back frames, no idle gap).
  - Otherwise next state = IDLE and busy = 0.
- Frame length from the first START cycle to the end of STOP: 1 + DATA_WIDTH + par_en_q + 1 cycles.
- Latency: Data_Valid high at edge N gives mux_sel = 00 and busy = 1 from edge N to edge N+1.
- ser_data holds its last value outside DATA; this is don't-care for the mux.
- Mid-frame changes to PAR_EN or PAR_TYP have no effect until the next accept.

Decomposition:
- Shared package uart_tx_pkg:
  - state encoding constants (IDLE, START, DATA, PARITY, STOP);
  - MUX_SEL_START/DATA/PAR/STOP constants (00/01/10/11), shared with the output mux;
  - default DATA_WIDTH.
- One natural sub-module: uart_parity_calc.
  - Combinational: data and PAR_TYP in, parity out.
  - Its output is registered in uart_tx_ctrl at accept.

Test Plan:
- P_DATA=8'hA5, PAR_EN=1, PAR_TYP=0, one-cycle Data_Valid:
  - mux_sel = 00, 01×8, 10, 11.
  - ser_data during DATA = 1,0,1,0,0,1,0,1; par_bit = 0.
  - busy high for exactly 11 cycles, then IDLE.
- P_DATA=8'h01, PAR_EN=1:
  - PAR_TYP=1 gives par_bit = 0.
  - PAR_TYP=0 gives par_bit = 1.
  - Frame is 11 cycles.
- P_DATA=8'hFF, PAR_EN=0:
  - mux_sel never takes 10; frame is 10 cycles; par_en_q = 0.
- Back-to-back: Data_Valid held high with 8'h3C then 8'hC3:
  - START follows STOP directly; busy never drops between frames.
  - Second-frame ser_data = 1,1,0,0,0,0,1,1.
- Data_Valid pulsed with P_DATA=8'h00 during the DATA state of a 8'hA5 frame:
  - Pulse is ignored; frame completes as scenario 1.
  - No new START after STOP.
- RST asserted during DATA bit 3, asynchronous mid-cycle:
  - Outputs go immediately to mux_sel = 11, busy = 0, par_bit = 0, par_en_q = 0.
  - After release, Data_Valid with 8'h5A starts a clean 11-cycle frame.

Source files
------------

// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_pkg
// Brief    : Shared state encoding, output-mux select codes and default width
//            for the UART transmit path.
// Revision : 1.0 - initial release
// ============================================================================
package uart_tx_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Select codes consumed by the downstream TX output mux
    localparam logic [1:0] MUX_SEL_START = 2'b00;
    localparam logic [1:0] MUX_SEL_DATA  = 2'b01;
    localparam logic [1:0] MUX_SEL_PAR   = 2'b10;
    localparam logic [1:0] MUX_SEL_STOP  = 2'b11;

endpackage : uart_tx_pkg
`default_nettype wire

// File: rtl/uart_parity_calc.sv
`default_nettype none
// ============================================================================
// Module   : uart_parity_calc
// Brief    : Combinational parity of a data word; i_par_typ 0 = even, 1 = odd.
// Revision : 1.0 - initial release
// ============================================================================
module uart_parity_calc #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_par_typ,
    output logic                  o_parity
);

    assign o_parity = (^i_data) ^ i_par_typ;

endmodule : uart_parity_calc
`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_ctrl
// Brief    : UART TX frame sequencer and serializer, one bit per CLK cycle,
//            feeding the TX output mux (select, data bit, parity bit).
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  ser_data,
    output logic                  par_bit,
    output logic                  par_en_q,
    output logic [1:0]            mux_sel,
    output logic                  busy
);

    localparam int              CNT_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(DATA_WIDTH - 1);

    tx_state_e               r_state;
    tx_state_e               w_next_state;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic [CNT_W-1:0]        r_bit_cnt;
    logic                    r_par_bit;
    logic                    r_par_en;
    logic                    r_ser_hold;
    logic                    w_parity;
    logic                    w_accept;
    logic                    w_ser_data;

    uart_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .i_data    (P_DATA),
        .i_par_typ (PAR_TYP),
        .o_parity  (w_parity)
    );

    // STOP accepts too, so back-to-back frames need no idle gap
    assign w_accept = Data_Valid && ((r_state == ST_IDLE) || (r_state == ST_STOP));

    always_comb begin
        w_next_state = r_state;
        mux_sel      = MUX_SEL_STOP;
        busy         = 1'b1;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (w_accept) w_next_state = ST_START;
            end
            ST_START: begin
                mux_sel      = MUX_SEL_START;
                w_next_state = ST_DATA;
            end
            ST_DATA: begin
                mux_sel = MUX_SEL_DATA;
                if (r_bit_cnt == c_last_bit)
                    w_next_state = r_par_en ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                mux_sel      = MUX_SEL_PAR;
                w_next_state = ST_STOP;
            end
            ST_STOP: begin
                w_next_state = w_accept ? ST_START : ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Outside DATA the serial bit holds whatever was last driven
    assign w_ser_data = (r_state == ST_DATA) ? r_shift[0] : r_ser_hold;
    assign ser_data   = w_ser_data;
    assign par_bit    = r_par_bit;
    assign par_en_q   = r_par_en;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= ST_IDLE;
            r_ser_hold <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_ser_hold <= w_ser_data;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_shift   <= '0;
            r_par_bit <= 1'b0;
            r_par_en  <= 1'b0;
        end else if (w_accept) begin
            r_shift   <= P_DATA;
            r_par_bit <= w_parity;
            r_par_en  <= PAR_EN;
        end else if (r_state == ST_DATA) begin
            r_shift   <= r_shift >> 1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_bit_cnt <= '0;
        end else if (r_state == ST_START) begin
            r_bit_cnt <= '0;
        end else if (r_state == ST_DATA) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
        end
    end

endmodule : uart_tx_ctrl
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_ctrl
// Brief    : Self-checking bench for uart_tx_ctrl: vector table plus corner
//            sequences, with a per-cycle expected-output scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_ctrl;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic [W-1:0] P_DATA = '0;
    logic         Data_Valid = 1'b0;
    logic         PAR_EN = 1'b0;
    logic         PAR_TYP = 1'b0;
    logic         ser_data;
    logic         par_bit;
    logic         par_en_q;
    logic [1:0]   mux_sel;
    logic         busy;

    uart_tx_ctrl #(
        .DATA_WIDTH (W)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .ser_data   (ser_data),
        .par_bit    (par_bit),
        .par_en_q   (par_en_q),
        .mux_sel    (mux_sel),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0] mux;
        logic       bsy;
        logic       chk_ser;
        logic       ser;
        logic       par;
        logic       pen;
    } exp_t;

    typedef struct {
        logic [W-1:0] d;
        logic         pe;
        logic         pt;
        logic         exp_par;
        int           exp_len;
    } vec_t;

    exp_t q[$];
    vec_t vecs[5];
    int   n_err = 0;
    int   n_chk = 0;
    int   busy_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] m, input logic b, input logic cs,
                                input logic s, input logic p, input logic pe);
        exp_t e;
        e.mux = m; e.bsy = b; e.chk_ser = cs; e.ser = s; e.par = p; e.pen = pe;
        return e;
    endfunction

    // Expected per-cycle outputs from the first START cycle onward
    task automatic push_frame(input logic [W-1:0] d, input logic pe, input logic pt, input bit idle);
        logic p;
        p = (^d) ^ pt;
        q.push_back(mk(2'b00, 1'b1, 1'b0, 1'b0, p, pe));
        for (int i = 0; i < W; i++) q.push_back(mk(2'b01, 1'b1, 1'b1, d[i], p, pe));
        if (pe) q.push_back(mk(2'b10, 1'b1, 1'b0, 1'b0, p, pe));
        q.push_back(mk(2'b11, 1'b1, 1'b0, 1'b0, p, pe));
        if (idle) q.push_back(mk(2'b11, 1'b0, 1'b0, 1'b0, p, pe));
    endtask

    task automatic drain_n(input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            if (q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL scoreboard_underrun actual=0 required=1");
                return;
            end
            @(negedge CLK);
            e = q.pop_front();
            chk("mux_sel", 32'(mux_sel), 32'(e.mux));
            chk("busy", 32'(busy), 32'(e.bsy));
            if (e.chk_ser) chk("ser_data", 32'(ser_data), 32'(e.ser));
            chk("par_bit", 32'(par_bit), 32'(e.par));
            chk("par_en_q", 32'(par_en_q), 32'(e.pen));
            if (busy) busy_cnt++;
        end
    endtask

    task automatic drain_all();
        drain_n(q.size());
    endtask

    // One-cycle Data_Valid; inputs are scrambled right after accept
    task automatic send(input logic [W-1:0] d, input logic pe, input logic pt);
        @(posedge CLK); #1;
        Data_Valid = 1'b1; P_DATA = d; PAR_EN = pe; PAR_TYP = pt;
        @(posedge CLK); #1;
        Data_Valid = 1'b0; P_DATA = ~d; PAR_EN = ~pe; PAR_TYP = ~pt;
        push_frame(d, pe, pt, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 11};
        vecs[1] = '{8'h01, 1'b1, 1'b1, 1'b0, 11};
        vecs[2] = '{8'h01, 1'b1, 1'b0, 1'b1, 11};
        vecs[3] = '{8'hFF, 1'b0, 1'b0, 1'b0, 10};
        vecs[4] = '{8'h5A, 1'b0, 1'b1, 1'b1, 10};

        // Reset values
        #12;
        chk("rst_mux_sel", 32'(mux_sel), 32'h3);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ser_data", 32'(ser_data), 32'h0);
        chk("rst_par_bit", 32'(par_bit), 32'h0);
        chk("rst_par_en_q", 32'(par_en_q), 32'h0);
        #6 RST = 1'b1;

        foreach (vecs[v]) begin
            busy_cnt = 0;
            send(vecs[v].d, vecs[v].pe, vecs[v].pt);
            drain_all();
            chk("frame_len", 32'(busy_cnt), 32'(vecs[v].exp_len));
            chk("par_bit_tbl", 32'(par_bit), 32'(vecs[v].exp_par));
        end

        // Back-to-back: Data_Valid held high across STOP
        @(posedge CLK); #1;
        Data_Valid = 1'b1; P_DATA = 8'h3C; PAR_EN = 1'b1; PAR_TYP = 1'b0;
        @(posedge CLK); #1;
        P_DATA = 8'hC3;
        push_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        push_frame(8'hC3, 1'b1, 1'b0, 1'b1);
        busy_cnt = 0;
        drain_n(11);
        @(posedge CLK); #1;
        Data_Valid = 1'b0;
        drain_all();
        chk("b2b_busy_len", 32'(busy_cnt), 32'd22);

        // Data_Valid pulse during DATA must be ignored
        busy_cnt = 0;
        send(8'hA5, 1'b1, 1'b0);
        drain_n(3);
        @(posedge CLK); #1;
        Data_Valid = 1'b1; P_DATA = 8'h00;
        drain_n(1);
        @(posedge CLK); #1;
        Data_Valid = 1'b0;
        drain_all();
        q.push_back(mk(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        q.push_back(mk(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        drain_n(2);
        chk("ignored_pulse_len", 32'(busy_cnt), 32'd11);

        // Asynchronous reset in the middle of data bit 3
        send(8'hA5, 1'b1, 1'b1);
        drain_n(4);
        @(posedge CLK); #2;
        RST = 1'b0;
        #1;
        chk("midrst_mux_sel", 32'(mux_sel), 32'h3);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_par_bit", 32'(par_bit), 32'h0);
        chk("midrst_par_en_q", 32'(par_en_q), 32'h0);
        q.delete();
        @(negedge CLK);
        RST = 1'b1;
        busy_cnt = 0;
        send(8'h5A, 1'b1, 1'b0);
        drain_all();
        chk("post_rst_len", 32'(busy_cnt), 32'd11);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_uart_tx_ctrl
`default_nettype wire
